reg_file_sb: RTL and testbench

Parametrised, clocked register file with a configurable number of combinational read ports, one general write port, a dedicated R0 write port for multiply/divide results, and a per-register scoreboard of pending writes. It sits between decode and execute: decode reads operands and busy flags, reserves the destination at issue, and write-back clears the reservation when the result is written. Out-of-range register numbers raise a sticky registered exception.

---
 rtl/reg_file_sb.sv | 103 ++++++++++
 tb/tb_reg_file_sb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with combinational read ports, general and R0 write ports, per-register busy scoreboard
// and a sticky illegal-register exception. Optional write-through bypass: define REG_FILE_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_WIDTH    = 16,
  parameter int REG_NUM_WIDTH = 4,
  parameter int NUM_REG       = 16,
  parameter int NUM_RD_PORTS  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_RD_PORTS*REG_NUM_WIDTH-1:0] rn,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd,
  output logic [NUM_RD_PORTS-1:0]               rd_busy,
  input  logic                                  wr,
  input  logic [REG_NUM_WIDTH-1:0]              wrn,
  input  logic [DATA_WIDTH-1:0]                 wrd,
  input  logic                                  wr0,
  input  logic [DATA_WIDTH-1:0]                 r0d,
  output logic [DATA_WIDTH-1:0]                 rd0,
  input  logic                                  resv,
  input  logic [REG_NUM_WIDTH-1:0]              resvn,
  input  logic                                  resv0,
  input  logic                                  exc_clr,
  output logic                                  exception
);

  // No handshakes: every enable is a single-cycle qualifier sampled on the rising edge,
  // and any combination of enables may be active in the same cycle.

  logic [DATA_WIDTH-1:0] rfile [NUM_REG];
  logic [NUM_REG-1:0]    busy;
  logic [NUM_REG-1:0]    busy_set;
  logic [NUM_REG-1:0]    busy_clr;
  logic                  illegal;

  function automatic logic legal(input logic [REG_NUM_WIDTH-1:0] n);
    return int'(n) < NUM_REG;
  endfunction

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      busy_set[i] = (resv && resvn == REG_NUM_WIDTH'(i)) || (resv0 && i == 0);
      busy_clr[i] = (wr && wrn == REG_NUM_WIDTH'(i)) || (wr0 && i == 0);
    end
  end

  always_comb begin
    illegal = (wr && !legal(wrn)) || (resv && !legal(resvn));
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (!legal(rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH])) illegal = 1'b1;
    end
  end

  // The R0 port outranks a general write to R0; a reservation outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REG; i++) rfile[i] <= '0;
      busy      <= '0;
      exception <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) begin
        if (wr0 && i == 0)    rfile[i] <= r0d;
        else if (busy_clr[i]) rfile[i] <= wrd;
      end
      busy      <= busy_set | (busy & ~busy_clr);
      exception <= illegal | (exception & ~exc_clr);
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      logic [REG_NUM_WIDTH-1:0] idx;
      idx = rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH];
      if (rst && legal(idx)) begin
`ifdef REG_FILE_BYPASS_EN
        if (wr0 && idx == '0)   rd[p*DATA_WIDTH +: DATA_WIDTH] = r0d;
        else if (wr && idx == wrn) rd[p*DATA_WIDTH +: DATA_WIDTH] = wrd;
        else                    rd[p*DATA_WIDTH +: DATA_WIDTH] = rfile[idx];
        rd_busy[p] = busy[idx] & ~busy_clr[idx];
`else
        rd[p*DATA_WIDTH +: DATA_WIDTH] = rfile[idx];
        rd_busy[p] = busy[idx];
`endif
      end
    end
  end

  always_comb begin
    rd0 = '0;
    if (rst) begin
`ifdef REG_FILE_BYPASS_EN
      rd0 = wr0 ? r0d : rfile[0];
`else
      rd0 = rfile[0];
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (NUM_REG=12, four read ports);
// expected values are hand-computed and follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file_sb;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int NR = 12;
  localparam int NP = 4;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NP*RW-1:0] rn = '0;
  logic [NP*DW-1:0] rd;
  logic [NP-1:0]  rd_busy;
  logic           wr = 1'b0, wr0 = 1'b0, resv = 1'b0, resv0 = 1'b0, exc_clr = 1'b0;
  logic [RW-1:0]  wrn = '0, resvn = '0;
  logic [DW-1:0]  wrd = '0, r0d = '0;
  logic [DW-1:0]  rd0;
  logic           exception;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  reg_file_sb #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .NUM_REG(NR), .NUM_RD_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .rn(rn), .rd(rd), .rd_busy(rd_busy),
    .wr(wr), .wrn(wrn), .wrd(wrd), .wr0(wr0), .r0d(r0d), .rd0(rd0),
    .resv(resv), .resvn(resvn), .resv0(resv0), .exc_clr(exc_clr), .exception(exception)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] port_rd(input int p);
    return rd[p*DW +: DW];
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; wr0 = 1'b0; resv = 1'b0; resv0 = 1'b0; exc_clr = 1'b0;
  endtask

  task automatic set_rn(input int p, input logic [RW-1:0] n);
    rn[p*RW +: RW] = n;
  endtask

  task automatic do_wr(input logic [RW-1:0] n, input logic [DW-1:0] d);
    wr = 1'b1; wrn = n; wrd = d;
  endtask

  initial begin
    // Reset state
    #12; settle();
    check("rst_exc", exception, 0);
    check("rst_rd0", rd0, 0);
    rst = 1'b1;
    tick();

    // Write R5, reserve R6, illegal read on port 3; then async reset mid-cycle
    do_wr(4'd5, 16'h1234); resv = 1'b1; resvn = 4'd6; set_rn(3, 4'd13);
    tick(); idle(); set_rn(3, 4'd0);
    set_rn(0, 4'd5); set_rn(1, 4'd6); settle();
    check("pre_rst_r5", port_rd(0), 16'h1234);
    check("pre_rst_busy6", rd_busy[1], 1);
    check("pre_rst_exc", exception, 1);
    #2 rst = 1'b0; settle();
    check("rst_r5", port_rd(0), 16'h0000);
    check("rst_busy", rd_busy, 0);
    check("rst_exc_async", exception, 0);
    tick(); rst = 1'b1; tick();
    check("post_rst_r5", port_rd(0), 16'h0000);

    // Write/read R3 on two ports
    do_wr(4'd3, 16'hBEEF); set_rn(0, 4'd3); set_rn(1, 4'd3); settle();
    check("r3_same_cycle", port_rd(0), BYP ? 16'hBEEF : 16'h0000);
    tick(); idle(); settle();
    check("r3_p0", port_rd(0), 16'hBEEF);
    check("r3_p1", port_rd(1), 16'hBEEF);

    // R0 collision: dedicated R0 port wins
    do_wr(4'd0, 16'h1111); wr0 = 1'b1; r0d = 16'h2222; set_rn(0, 4'd0); settle();
    check("r0_same_rd0", rd0, BYP ? 16'h2222 : 16'h0000);
    tick(); idle(); settle();
    check("r0_rd0", rd0, 16'h2222);
    check("r0_port", port_rd(0), 16'h2222);

    // Scoreboard on R7
    resv = 1'b1; resvn = 4'd7; set_rn(0, 4'd7); settle();
    check("busy7_same", rd_busy[0], 0);
    tick(); idle(); settle();
    check("busy7_set", rd_busy[0], 1);
    resv = 1'b1; resvn = 4'd7; do_wr(4'd7, 16'h0055);
    tick(); idle(); settle();
    check("busy7_setwins", rd_busy[0], 1);
    check("r7_55", port_rd(0), 16'h0055);
    do_wr(4'd7, 16'h00AA); settle();
    check("busy7_clr_same", rd_busy[0], BYP ? 1'b0 : 1'b1);
    check("r7_aa_same", port_rd(0), BYP ? 16'h00AA : 16'h0055);
    tick(); idle(); settle();
    check("busy7_clr", rd_busy[0], 0);
    check("r7_aa", port_rd(0), 16'h00AA);

    // R0 scoreboard: resv0 sets, wr0 clears, both together stays set
    resv0 = 1'b1; set_rn(1, 4'd0);
    tick(); idle(); settle();
    check("busy0_set", rd_busy[1], 1);
    wr0 = 1'b1; r0d = 16'h3333; resv0 = 1'b1;
    tick(); idle(); settle();
    check("busy0_setwins", rd_busy[1], 1);
    wr0 = 1'b1; r0d = 16'h4444;
    tick(); idle(); settle();
    check("busy0_clr", rd_busy[1], 0);
    check("rd0_4444", rd0, 16'h4444);

    // Illegal write: no state change, sticky exception
    do_wr(4'd13, 16'hDEAD); set_rn(0, 4'd3); set_rn(1, 4'd7); set_rn(2, 4'd5); settle();
    check("exc_same", exception, 0);
    tick(); idle(); settle();
    check("exc_wr13", exception, 1);
    check("ill_r3", port_rd(0), 16'hBEEF);
    check("ill_r7", port_rd(1), 16'h00AA);
    check("ill_r5", port_rd(2), 16'h0000);
    check("ill_rd0", rd0, 16'h4444);
    tick(); settle();
    check("exc_hold", exception, 1);
    exc_clr = 1'b1; set_rn(1, 4'd14); settle();
    check("ill_rd_zero", port_rd(1), 16'h0000);
    check("ill_busy_zero", rd_busy[1], 0);
    tick(); idle(); set_rn(1, 4'd0); settle();
    check("exc_clr_vs_new", exception, 1);
    exc_clr = 1'b1;
    tick(); idle(); settle();
    check("exc_cleared", exception, 0);
    resv = 1'b1; resvn = 4'd12;
    tick(); idle(); settle();
    check("exc_resv12", exception, 1);
    check("busy_none", rd_busy, 0);
    exc_clr = 1'b1;
    tick(); idle(); settle();
    check("exc_cleared2", exception, 0);

    // Multi-port read of R1..R4
    for (int i = 1; i <= 4; i++) begin
      do_wr(RW'(i), DW'(i));
      tick();
    end
    idle();
    for (int p = 0; p < NP; p++) begin
      set_rn(p, RW'(p + 1));
      exp_q.push_back(64'(p + 1));
    end
    settle();
    for (int p = 0; p < NP; p++) check($sformatf("mp_port%0d", p), 64'(port_rd(p)), exp_q.pop_front());
    check("mp_packed", rd, 64'h0004_0003_0002_0001);
    check("mp_busy", rd_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
